pe_mac: RTL and testbench

Processing element that sits directly downstream of the ring switch. It consumes the packets the switch delivers for this rank and executes a small weight/multiply-accumulate instruction set. It returns result nibbles to the switch's PE input, and the switch injects them onto the ring. Tokens are exchanged by change-detect: a new token is signalled by the 8-bit bus value differing from the last value taken.

---
 rtl/pe_mac.sv | 140 ++++++++++++++
 tb/tb_pe_mac.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_mac.sv
// Processing element behind the ring switch: queues this rank's tokens and runs a
// small weight / multiply-accumulate instruction set, emitting result nibbles back.
module pe_mac #(
  parameter int RANK       = 0,
  parameter int CHECK_RANK = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] pe_in,
  output logic [7:0] pe_out,
  output logic       busy,
  output logic       overflow,
  output logic [7:0] acc
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = AW + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [AW-1:0]    PTR_ONE   = AW'(1);
  localparam logic [1:0]       RANK_BITS = 2'(RANK);

  typedef enum logic {IDLE, MUL} state_t;

  state_t           state_q, state_d;
  logic [7:0]       prev_in_q, prev_in_d;
  logic [7:0]       acc_q, acc_d;
  logic [7:0]       pe_out_q, pe_out_d;
  logic [3:0]       w_q, w_d;
  logic [3:0]       b_q, b_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             seq_q, seq_d;
  logic             overflow_q, overflow_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Entries hold {opcode, operand}; rank bits are only needed at detect time.
  logic [5:0] fifo_mem [FIFO_DEPTH];
  logic [5:0] head;

  logic detect, rank_ok, full, pop, push, drop;

  assign detect  = (pe_in != prev_in_q);
  assign rank_ok = (CHECK_RANK == 0) || (pe_in[5:4] == RANK_BITS);
  assign full    = (count_q == DEPTH_CNT);
  assign pop     = (state_q == IDLE) && (count_q != '0);
  // A full FIFO still accepts when the head leaves at the same edge.
  assign push    = detect && rank_ok && (!full || pop);
  assign drop    = detect && rank_ok && full && !pop;
  assign head    = fifo_mem[rd_ptr_q];

  always_comb begin
    state_d    = state_q;
    prev_in_d  = pe_in;
    acc_d      = acc_q;
    pe_out_d   = pe_out_q;
    w_d        = w_q;
    b_d        = b_q;
    cnt_d      = cnt_q;
    seq_d      = seq_q;
    overflow_d = overflow_q | drop;
    wr_ptr_d   = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d    = count_q;
    if (push && !pop) count_d = count_q + CNT_ONE;
    if (pop && !push) count_d = count_q - CNT_ONE;

    case (state_q)
      IDLE: begin
        if (pop) begin
          case (head[5:4])
            2'b00: w_d = head[3:0];
            2'b01: begin
              b_d     = head[3:0];
              cnt_d   = 2'd0;
              state_d = MUL;
            end
            2'b10: begin
              seq_d    = ~seq_q;
              pe_out_d = {~seq_q, 3'b000, (head[0] ? acc_q[7:4] : acc_q[3:0])};
            end
            default: begin
              acc_d = 8'h00;
              if (head[0]) w_d = 4'h0;
            end
          endcase
        end
      end
      MUL: begin
        // Shift-add, one multiplier bit per edge, LSB first; sum wraps mod 256.
        if (b_q[cnt_q]) acc_d = acc_q + ({4'h0, w_q} << cnt_q);
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {pe_in[7:6], pe_in[3:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      prev_in_q  <= 8'h00;
      acc_q      <= 8'h00;
      pe_out_q   <= 8'h00;
      w_q        <= 4'h0;
      b_q        <= 4'h0;
      cnt_q      <= 2'd0;
      seq_q      <= 1'b0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      prev_in_q  <= prev_in_d;
      acc_q      <= acc_d;
      pe_out_q   <= pe_out_d;
      w_q        <= w_d;
      b_q        <= b_d;
      cnt_q      <= cnt_d;
      seq_q      <= seq_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  assign pe_out   = pe_out_q;
  assign acc      = acc_q;
  assign overflow = overflow_q;
  assign busy     = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_pe_mac.sv
// Bench for pe_mac: directed scenarios on a rank-0 tile and randomized traffic on a
// rank-1 filtering tile, checked against an instruction-level model.
module tb_pe_mac;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] pe_in0 = 8'h00;
  logic [7:0] pe_in1 = 8'h00;
  logic [7:0] pe_out0, pe_out1, acc0, acc1;
  logic       busy0, busy1, ovf0, ovf1;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  pe_mac #(.RANK(0), .CHECK_RANK(1), .FIFO_DEPTH(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .pe_in(pe_in0), .pe_out(pe_out0),
    .busy(busy0), .overflow(ovf0), .acc(acc0)
  );

  pe_mac #(.RANK(1), .CHECK_RANK(1), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .pe_in(pe_in1), .pe_out(pe_out1),
    .busy(busy1), .overflow(ovf1), .acc(acc1)
  );

  task automatic do_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    pe_in0 = 8'h00;
    pe_in1 = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic send0(input logic [7:0] v, input int hold);
    pe_in0 = v;
    repeat (hold) @(negedge clk);
  endtask

  task automatic send1(input logic [7:0] v, input int hold);
    pe_in1 = v;
    repeat (hold) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({pe_out0, acc0, busy0, ovf0} !== {8'h00, 8'h00, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset_idle cyc %0d: pe_out=%h acc=%h busy=%b ovf=%b, want 00 00 0 0",
                 i, pe_out0, acc0, busy0, ovf0);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    do_reset();
    send0(8'h03, 8);
    pe_in0 = 8'h45;
    repeat (5) @(negedge clk);
    checks++;
    if (busy0 !== 1'b1) begin
      errors++;
      $display("FAIL mac_busy_pop_plus3: busy=%b want 1", busy0);
    end
    @(negedge clk);
    checks++;
    if (busy0 !== 1'b0) begin
      errors++;
      $display("FAIL mac_done_pop_plus4: busy=%b want 0", busy0);
    end
    checks++;
    if (acc0 !== 8'h0F) begin
      errors++;
      $display("FAIL basic_mac: acc=%h want 0f", acc0);
    end
    send0(8'h80, 8);
    checks++;
    if (pe_out0 !== 8'h8F) begin
      errors++;
      $display("FAIL emit_low: pe_out=%h want 8f", pe_out0);
    end
    send0(8'h81, 8);
    checks++;
    if (pe_out0 !== 8'h00) begin
      errors++;
      $display("FAIL emit_high: pe_out=%h want 00", pe_out0);
    end
    $display("test_basic done acc=%h pe_out=%h", acc0, pe_out0);
  endtask

  task automatic test_wrap();
    do_reset();
    send0(8'h0F, 8);
    send0(8'h4F, 8);
    checks++;
    if (acc0 !== 8'hE1) begin
      errors++;
      $display("FAIL wrap_first: acc=%h want e1", acc0);
    end
    send0(8'h40, 8);
    checks++;
    if (acc0 !== 8'hE1) begin
      errors++;
      $display("FAIL wrap_b_zero: acc=%h want e1", acc0);
    end
    send0(8'h4F, 8);
    checks++;
    if (acc0 !== 8'hC2) begin
      errors++;
      $display("FAIL wrap_second: acc=%h want c2", acc0);
    end
    $display("test_wrap done acc=%h", acc0);
  endtask

  task automatic test_overflow();
    do_reset();
    send0(8'h01, 8);
    for (int i = 1; i <= 5; i++) send0(8'h40 + 8'(i), 1);
    checks++;
    if (ovf0 !== 1'b0) begin
      errors++;
      $display("FAIL ovf_early: overflow=%b want 0", ovf0);
    end
    send0(8'h46, 1);
    checks++;
    if (ovf0 !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: overflow=%b want 1", ovf0);
    end
    repeat (30) @(negedge clk);
    checks++;
    if ({acc0, ovf0, busy0} !== {8'h0F, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL ovf_final: acc=%h ovf=%b busy=%b want 0f 1 0", acc0, ovf0, busy0);
    end
    do_reset();
    checks++;
    if (ovf0 !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: overflow=%b want 0", ovf0);
    end
    $display("test_overflow done");
  endtask

  task automatic test_back_to_back();
    do_reset();
    send0(8'h0F, 8);
    send0(8'h41, 8);
    pe_in0 = 8'h80;
    @(negedge clk);
    checks++;
    if (pe_out0 !== 8'h00) begin
      errors++;
      $display("FAIL b2b_not_yet: pe_out=%h want 00", pe_out0);
    end
    pe_in0 = 8'h81;
    @(negedge clk);
    checks++;
    if (pe_out0 !== 8'h8F) begin
      errors++;
      $display("FAIL b2b_first: pe_out=%h want 8f", pe_out0);
    end
    pe_in0 = 8'h80;
    @(negedge clk);
    checks++;
    if (pe_out0 !== 8'h00) begin
      errors++;
      $display("FAIL b2b_second: pe_out=%h want 00", pe_out0);
    end
    @(negedge clk);
    checks++;
    if (pe_out0 !== 8'h8F) begin
      errors++;
      $display("FAIL b2b_third: pe_out=%h want 8f", pe_out0);
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_rank_filter();
    do_reset();
    send1(8'h03, 2);
    checks++;
    if ({busy1, ovf1} !== 2'b00) begin
      errors++;
      $display("FAIL rank_discard: busy=%b ovf=%b want 0 0", busy1, ovf1);
    end
    send1(8'h03, 6);
    send1(8'h13, 8);
    send1(8'h55, 8);
    send1(8'h90, 8);
    checks++;
    if ({pe_out1, acc1, ovf1} !== {8'h8F, 8'h0F, 1'b0}) begin
      errors++;
      $display("FAIL rank_accept: pe_out=%h acc=%h ovf=%b want 8f 0f 0", pe_out1, acc1, ovf1);
    end
    $display("test_rank_filter done");
  endtask

  task automatic test_reset_mid_mul();
    do_reset();
    send0(8'h03, 8);
    send0(8'h45, 8);
    send0(8'h80, 8);
    pe_in0 = 8'h45;
    repeat (4) @(negedge clk);
    checks++;
    if ({acc0, busy0} !== {8'h12, 1'b1}) begin
      errors++;
      $display("FAIL mid_mul: acc=%h busy=%b want 12 1", acc0, busy0);
    end
    rst_n  = 1'b0;
    pe_in0 = 8'h00;
    #1;
    checks++;
    if ({pe_out0, acc0, busy0, ovf0} !== {8'h00, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: pe_out=%h acc=%h busy=%b ovf=%b want 00 00 0 0",
               pe_out0, acc0, busy0, ovf0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({acc0, busy0} !== {8'h00, 1'b0}) begin
      errors++;
      $display("FAIL after_reset: acc=%h busy=%b want 00 0", acc0, busy0);
    end
    send0(8'h80, 8);
    checks++;
    if (pe_out0 !== 8'h80) begin
      errors++;
      $display("FAIL emit_after_reset: pe_out=%h want 80", pe_out0);
    end
    $display("test_reset_mid_mul done");
  endtask

  // Instruction-level model: each distinct token for rank 1 executes in full.
  task automatic test_random();
    logic [7:0] tok, prev, m_acc, m_out;
    logic [3:0] m_w;
    logic       m_seq;
    do_reset();
    prev = 8'h00; m_acc = 8'h00; m_out = 8'h00; m_w = 4'h0; m_seq = 1'b0;
    for (int n = 0; n < 40; n++) begin
      tok = 8'($urandom);
      if ($urandom_range(0, 1) == 1) tok[5:4] = 2'b01;
      if (tok != prev) begin
        prev = tok;
        if (tok[5:4] == 2'b01) begin
          case (tok[7:6])
            2'b00: m_w = tok[3:0];
            2'b01: m_acc = 8'((int'(m_acc) + int'(m_w) * int'(tok[3:0])) % 256);
            2'b10: begin
              m_out = {~m_seq, 3'b000, (tok[0] ? m_acc[7:4] : m_acc[3:0])};
              m_seq = ~m_seq;
            end
            default: begin
              m_acc = 8'h00;
              if (tok[0]) m_w = 4'h0;
            end
          endcase
        end
      end
      send1(tok, 7);
      checks++;
      if ({acc1, pe_out1, busy1, ovf1} !== {m_acc, m_out, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL random[%0d] tok=%h: acc=%h pe_out=%h busy=%b ovf=%b want %h %h 0 0",
                 n, tok, acc1, pe_out1, busy1, ovf1, m_acc, m_out);
      end
    end
    $display("test_random done acc=%h pe_out=%h", acc1, pe_out1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_overflow();
    test_back_to_back();
    test_rank_filter();
    test_reset_mid_mul();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
